// File: rtl/div_share_ctrl_if.sv
// Request/response handshake bundle between two requesters and the shared-divider controller.
// The master modport is the requester side; the slave modport is the controller side.
interface div_share_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_dividend;
  logic [WIDTH-1:0] req0_divisor;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_dividend;
  logic [WIDTH-1:0] req1_divisor;
  logic             resp0_valid;
  logic             resp0_ready;
  logic             resp1_valid;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp_quotient;
  logic [WIDTH-1:0] resp_remainder;
  logic             resp_div_zero;

  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid,
    input  resp_quotient, resp_remainder, resp_div_zero
  );

  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid,
    output resp_quotient, resp_remainder, resp_div_zero
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin sharing of one combinational divider between two requesters.
//  state | meaning
//  IDLE  | arbitrate and accept one request
//  WAIT  | operands held on the divider while its outputs settle
//  RESP  | result presented to the granted requester until taken
module div_share_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DIV_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  div_share_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy
);
  localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gid_q, gid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             any_v;
  logic             win;
  logic             accept;
  logic [WIDTH-1:0] win_dvd;
  logic [WIDTH-1:0] win_dvs;

  // prio only matters on a tie; a lone requester always wins
  assign any_v   = bus.req0_valid | bus.req1_valid;
  assign win     = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
  assign accept  = (state_q == IDLE) && any_v && !rst;
  assign win_dvd = win ? bus.req1_dividend : bus.req0_dividend;
  assign win_dvs = win ? bus.req1_divisor  : bus.req0_divisor;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          prio_d = ~win;
          gid_d  = win;
          dvd_d  = win_dvd;
          dvs_d  = win_dvs;
          if (win_dvs == '0) begin
            quo_d   = '1;
            rem_d   = win_dvd;
            dz_d    = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          dz_d    = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (gid_q ? bus.resp1_ready : bus.resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.req0_ready     = accept && !win;
  assign bus.req1_ready     = accept && win;
  assign bus.resp0_valid    = (state_q == RESP) && !gid_q;
  assign bus.resp1_valid    = (state_q == RESP) && gid_q;
  assign bus.resp_quotient  = quo_q;
  assign bus.resp_remainder = rem_q;
  assign bus.resp_div_zero  = dz_q;
  assign div_dividend       = dvd_q;
  assign div_divisor        = dvs_q;
  assign busy               = (state_q != IDLE);
endmodule
